// File: rtl/serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | serial_subtractor : bit-serial A - B - borrow_in, LSB first           |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_borrow_in,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_diff,
   output logic             o_borrow,
   output logic             o_overflow
);

   localparam int              CNT_W  = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [1:0]      C_IDLE = 2'd0;
   localparam logic [1:0]      C_RUN  = 2'd1;
   localparam logic [1:0]      C_DONE = 2'd2;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             br_q, br_d, borrow_q, borrow_d, ovf_q, ovf_d;

   logic w_accept, w_last, w_a0, w_b0, w_bit, w_br_next;

   assign w_accept  = i_start && ((state_q == C_IDLE) || (state_q == C_DONE));
   assign w_last    = (state_q == C_RUN) && (cnt_q == C_LAST);
   assign w_a0      = a_q[0];
   assign w_b0      = b_q[0];
   assign w_bit     = w_a0 ^ w_b0 ^ br_q;
   assign w_br_next = (~w_a0 & w_b0) | (~(w_a0 ^ w_b0) & br_q);

   // State register
   always_ff @(posedge i_clk) begin
      if (i_reset) state_q <= C_IDLE;
      else         state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         C_IDLE:  if (i_start) state_d = C_RUN;
         C_RUN:   if (w_last)  state_d = C_DONE;
         C_DONE:  state_d = i_start ? C_RUN : C_IDLE;
         default: state_d = C_IDLE;
      endcase
   end

   // Output decode, purely from registered state
   always_comb begin
      o_busy = (state_q == C_RUN);
      o_done = (state_q == C_DONE);
   end

   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      br_d     = br_q;
      cnt_d    = cnt_q;
      diff_d   = diff_q;
      borrow_d = borrow_q;
      ovf_d    = ovf_q;
      if (w_accept) begin
         a_d   = i_a;
         b_d   = i_b;
         br_d  = i_borrow_in;
         cnt_d = '0;
      end else if (state_q == C_RUN) begin
         a_d   = a_q >> 1;
         b_d   = b_q >> 1;
         res_d = {w_bit, res_q[WIDTH-1:1]};
         br_d  = w_br_next;
         cnt_d = cnt_q + 1'b1;
         // On the last bit the operand LSBs are the original sign bits
         if (w_last) begin
            diff_d   = {w_bit, res_q[WIDTH-1:1]};
            borrow_d = w_br_next;
            ovf_d    = (w_a0 != w_b0) && (w_bit != w_a0);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         br_q     <= 1'b0;
         cnt_q    <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         br_q     <= br_d;
         cnt_q    <= cnt_d;
         diff_q   <= diff_d;
         borrow_q <= borrow_d;
         ovf_q    <= ovf_d;
      end
   end

   assign o_diff     = diff_q;
   assign o_borrow   = borrow_q;
   assign o_overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_serial_subtractor : directed + random bench, 8-bit and 4-bit DUTs  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_serial_subtractor;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, bin, start4, bin4;
   logic [7:0] a, b;
   logic [3:0] a4, b4;
   logic       busy, done, bor, ovf, busy4, done4, bor4, ovf4;
   logic [7:0] diff;
   logic [3:0] diff4;

   int tests = 0;
   int fails = 0;
   logic [7:0] last_diff = 8'h00;
   logic       last_bor  = 1'b0;
   logic       last_ovf  = 1'b0;

   serial_subtractor #(.WIDTH(8)) dut8 (
      .i_clk(clk), .i_reset(rst), .i_start(start), .i_a(a), .i_b(b),
      .i_borrow_in(bin), .o_busy(busy), .o_done(done), .o_diff(diff),
      .o_borrow(bor), .o_overflow(ovf));

   serial_subtractor #(.WIDTH(4)) dut4 (
      .i_clk(clk), .i_reset(rst), .i_start(start4), .i_a(a4), .i_b(b4),
      .i_borrow_in(bin4), .o_busy(busy4), .o_done(done4), .o_diff(diff4),
      .o_borrow(bor4), .o_overflow(ovf4));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: unsigned 9-bit difference gives borrow; signed range gives overflow
   task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                      input bit scramble);
      logic [8:0] full;
      int         sr;
      full = {1'b0, ta} - {1'b0, tb} - 9'(tbin);
      sr   = int'($signed(ta)) - int'($signed(tb)) - int'(tbin);
      @(negedge clk);
      a = ta; b = tb; bin = tbin; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("busy_run", 32'(busy), 32'(1));
         chk("done_run", 32'(done), 32'(0));
         chk("diff_hold", 32'(diff), 32'(last_diff));
         chk("bor_hold", 32'(bor), 32'(last_bor));
         if (scramble) begin
            a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
            start = (i < 7) ? 1'($urandom) : 1'b0;
         end
         @(negedge clk);
      end
      chk("done_pulse", 32'(done), 32'(1));
      chk("busy_done", 32'(busy), 32'(0));
      chk("diff", 32'(diff), 32'(full[7:0]));
      chk("borrow", 32'(bor), 32'(full[8]));
      chk("overflow", 32'(ovf), 32'((sr < -128) || (sr > 127)));
      last_diff = full[7:0]; last_bor = full[8]; last_ovf = (sr < -128) || (sr > 127);
      @(negedge clk);
      chk("done_single", 32'(done), 32'(0));
   endtask

   task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic tbin);
      logic [4:0] full;
      int         sr;
      full = {1'b0, ta} - {1'b0, tb} - 5'(tbin);
      sr   = int'($signed(ta)) - int'($signed(tb)) - int'(tbin);
      @(negedge clk);
      a4 = ta; b4 = tb; bin4 = tbin; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      for (int i = 0; i < 8 && !done4; i++) @(negedge clk);
      chk("done4", 32'(done4), 32'(1));
      chk("diff4", 32'(diff4), 32'(full[3:0]));
      chk("borrow4", 32'(bor4), 32'(full[4]));
      chk("ovf4", 32'(ovf4), 32'((sr < -8) || (sr > 7)));
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; bin = 1'b0; a = '0; b = '0;
      start4 = 1'b0; bin4 = 1'b0; a4 = '0; b4 = '0;
      repeat (2) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_done", 32'(done), 32'(0));
      chk("rst_diff", 32'(diff), 32'(0));
      chk("rst_bor", 32'(bor), 32'(0));
      chk("rst_ovf", 32'(ovf), 32'(0));
      rst = 1'b0; start = 1'b0;

      op8(8'd5, 8'd3, 1'b0, 1'b0);
      chk("lit_5m3", 32'({bor, ovf, diff}), 32'({2'b00, 8'h02}));
      op8(8'd3, 8'd5, 1'b0, 1'b0);
      chk("lit_3m5", 32'({bor, ovf, diff}), 32'({2'b10, 8'hFE}));
      op8(8'h00, 8'h00, 1'b1, 1'b0);
      chk("lit_0m0b", 32'({bor, diff}), 32'({1'b1, 8'hFF}));
      op8(8'h80, 8'h01, 1'b0, 1'b0);
      chk("lit_80m01", 32'({bor, ovf, diff}), 32'({2'b01, 8'h7F}));
      op8(8'h7F, 8'hFF, 1'b0, 1'b0);
      chk("lit_7FmFF", 32'({bor, ovf, diff}), 32'({2'b11, 8'h80}));

      // Reset during the 4th RUN cycle abandons the operation
      @(negedge clk);
      a = 8'd200; b = 8'd100; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_outs", 32'({busy, done, bor, ovf, diff}), 32'(0));
      last_diff = 8'h00; last_bor = 1'b0; last_ovf = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("mid_rst_nodone", 32'(done), 32'(0));
      end
      op8(8'd10, 8'd7, 1'b0, 1'b0);
      chk("lit_10m7", 32'(diff), 32'(8'h03));

      // Held start with operands changed mid-run, then back-to-back accept
      @(negedge clk);
      a = 8'd5; b = 8'd3; bin = 1'b0; start = 1'b1;
      @(negedge clk);
      a = 8'd9; b = 8'd4;
      for (int i = 0; i < 8; i++) begin
         chk("b2b_done_early", 32'(done), 32'(0));
         @(negedge clk);
      end
      chk("b2b_done1", 32'(done), 32'(1));
      chk("b2b_diff1", 32'(diff), 32'(8'h02));
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         chk("b2b_gap", 32'(done), 32'(0));
         if (k == 1) start = 1'b0;
      end
      @(negedge clk);
      chk("b2b_done2", 32'(done), 32'(1));
      chk("b2b_diff2", 32'(diff), 32'(8'h05));
      @(negedge clk);
      chk("b2b_idle", 32'({busy, done}), 32'(0));
      last_diff = 8'h05; last_bor = 1'b0; last_ovf = 1'b0;

      for (int n = 0; n < 1000; n++)
         op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);

      for (int x = 0; x < 512; x++)
         op4(x[3:0], x[7:4], x[8]);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
